// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 field constants and the Jacobian-to-affine sequencer states.
package secp256k1_pkg;

  localparam int WIDTH = 256;

  localparam logic [WIDTH-1:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  localparam logic [WIDTH-1:0] B_COEFF = WIDTH'(7);

  typedef enum logic [3:0] {
    IDLE,
    INV_REQ,
    INV_WAIT,
    MUL_Z2,
    MUL_X,
    MUL_Z3,
    MUL_Y,
    CHK_Y2,
    CHK_X2,
    CHK_X3,
    CHK_CMP,
    DONE
  } state_t;

  // States that own the serial multiplier for one 258-cycle step.
  function automatic logic is_mul(input state_t s);
    return (s == MUL_Z2) || (s == MUL_X) || (s == MUL_Z3) || (s == MUL_Y) ||
           (s == CHK_Y2) || (s == CHK_X2) || (s == CHK_X3);
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial MSB-first interleaved modular multiplier, product = a*b mod P.
// One issue cycle plus 257 cycles to mul_done; product holds until next mul_start.
module mod_mul_serial
  import secp256k1_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             mul_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             mul_done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH+1:0] P_EXT = {2'b00, P};

  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH+1:0] acc, sum0, sum1, acc_nxt;
  logic [CW-1:0]    cnt;
  logic             running;

  // acc < P and b < P, so 2*acc + b < 3P: two conditional subtracts suffice.
  always_comb begin
    sum0    = (acc << 1) + (a_r[cnt] ? {2'b00, b_r} : '0);
    sum1    = (sum0 >= P_EXT) ? sum0 - P_EXT : sum0;
    acc_nxt = (sum1 >= P_EXT) ? sum1 - P_EXT : sum1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      cnt      <= '0;
      running  <= 1'b0;
      mul_done <= 1'b0;
    end else begin
      mul_done <= 1'b0;
      if (mul_start) begin
        a_r     <= a;
        b_r     <= b;
        acc     <= '0;
        cnt     <= CW'(WIDTH - 1);
        running <= 1'b1;
      end else if (running) begin
        acc <= acc_nxt;
        if (cnt == '0) begin
          running  <= 1'b0;
          mul_done <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign product = acc[WIDTH-1:0];

endmodule

// File: rtl/jacobian_to_affine.sv
// secp256k1 Jacobian (X,Y,Z) -> affine (X/Z^2, Y/Z^3) using an external inverter.
// Optional on-curve check of the result is built when AFFINE_CHECK_EN is defined.
module jacobian_to_affine
  import secp256k1_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic             infinity,
  output logic             on_curve,
  output logic             inv_start,
  output logic [WIDTH-1:0] inv_operand,
  input  logic [WIDTH-1:0] inv_result,
  input  logic             inv_done
);

  state_t state, state_nxt;

  logic [WIDTH-1:0] xr, yr, zi, t, xa, ya;
  logic             inf_r;
  logic             accept;

  logic             mul_start, mul_done, mul_issued;
  logic [WIDTH-1:0] mul_a, mul_b, product;

  // busy also covers the done cycle, so a start there is refused.
  assign accept    = (state == IDLE) && start && !busy;
  assign inv_start = (state == INV_REQ);
  assign mul_start = is_mul(state) && !mul_issued;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = (z_in == '0) ? DONE : INV_REQ;
      INV_REQ:  state_nxt = INV_WAIT;
      INV_WAIT: if (inv_done) state_nxt = MUL_Z2;
      MUL_Z2:   if (mul_done) state_nxt = MUL_X;
      MUL_X:    if (mul_done) state_nxt = MUL_Z3;
      MUL_Z3:   if (mul_done) state_nxt = MUL_Y;
`ifdef AFFINE_CHECK_EN
      MUL_Y:    if (mul_done) state_nxt = CHK_Y2;
      CHK_Y2:   if (mul_done) state_nxt = CHK_X2;
      CHK_X2:   if (mul_done) state_nxt = CHK_X3;
      CHK_X3:   if (mul_done) state_nxt = CHK_CMP;
      CHK_CMP:  state_nxt = DONE;
`else
      MUL_Y:    if (mul_done) state_nxt = DONE;
`endif
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // t carries Z^-2, then Z^-3, and in the check path x^2, then x^3.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_Z2: begin mul_a = zi; mul_b = zi; end
      MUL_X:  begin mul_a = xr; mul_b = t;  end
      MUL_Z3: begin mul_a = t;  mul_b = zi; end
      MUL_Y:  begin mul_a = yr; mul_b = t;  end
      CHK_Y2: begin mul_a = ya; mul_b = ya; end
      CHK_X2: begin mul_a = xa; mul_b = xa; end
      CHK_X3: begin mul_a = t;  mul_b = xa; end
      default: ;
    endcase
  end

  mod_mul_serial u_mul (
    .clk       (clk),
    .reset     (reset),
    .mul_start (mul_start),
    .a         (mul_a),
    .b         (mul_b),
    .mul_done  (mul_done),
    .product   (product)
  );

  always_ff @(posedge clk) begin
    if (reset)         mul_issued <= 1'b0;
    else if (mul_done) mul_issued <= 1'b0;
    else if (mul_start) mul_issued <= 1'b1;
  end

`ifdef AFFINE_CHECK_EN
  logic [WIDTH-1:0] y2;
  logic [WIDTH:0]   rhs_raw, rhs;
  logic             oc_r;

  // x^3 < P, so x^3 + 7 needs at most one subtract.
  assign rhs_raw = {1'b0, t} + {1'b0, B_COEFF};
  assign rhs     = (rhs_raw >= {1'b0, P}) ? rhs_raw - {1'b0, P} : rhs_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      y2       <= '0;
      oc_r     <= 1'b1;
      on_curve <= 1'b1;
    end else begin
      if (mul_done && state == CHK_Y2) y2 <= product;
      if (state == CHK_CMP)            oc_r <= (rhs == {1'b0, y2});
      if (state == DONE)               on_curve <= inf_r ? 1'b1 : oc_r;
    end
  end
`else
  assign on_curve = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      xr          <= '0;
      yr          <= '0;
      inv_operand <= '0;
      inf_r       <= 1'b0;
      zi          <= '0;
      t           <= '0;
      xa          <= '0;
      ya          <= '0;
      x_out       <= '0;
      y_out       <= '0;
      infinity    <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (done) busy <= 1'b0;
      if (accept) begin
        busy        <= 1'b1;
        xr          <= x_in;
        yr          <= y_in;
        inv_operand <= z_in;
        inf_r       <= (z_in == '0);
      end
      if (state == INV_WAIT && inv_done) zi <= inv_result;
      if (mul_done) begin
        case (state)
          MUL_Z2, MUL_Z3, CHK_X2, CHK_X3: t <= product;
          MUL_X: xa <= product;
          MUL_Y: ya <= product;
          default: ;
        endcase
      end
      if (state == DONE) begin
        x_out    <= inf_r ? '0 : xa;
        y_out    <= inf_r ? '0 : ya;
        infinity <= inf_r;
      end
    end
  end

endmodule
